// File: rtl/frame_buffer_dbl.sv
// Double-buffered pixel frame store: render logic writes the back bank while scan-out
// reads the front bank; banks swap atomically and a clear engine fills the back bank.
module frame_buffer_dbl #(
  parameter int                 H_PIX     = 160,
  parameter int                 V_PIX     = 120,
  parameter int                 BPC       = 4,
  parameter logic [3*BPC-1:0]   CLEAR_RGB = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [$clog2(H_PIX)-1:0]   wr_x,
  input  logic [$clog2(V_PIX)-1:0]   wr_y,
  input  logic [3*BPC-1:0]           wr_rgb,
  output logic                       wr_ready,
  input  logic                       rd_en,
  input  logic [$clog2(H_PIX)-1:0]   rd_x,
  input  logic [$clog2(V_PIX)-1:0]   rd_y,
  output logic [3*BPC-1:0]           rd_rgb,
  output logic                       rd_valid,
  input  logic                       swap_req,
  output logic                       swap_done,
  input  logic                       clear_req,
  output logic                       busy
);
  localparam int PW   = 3 * BPC;
  localparam int NPIX = H_PIX * V_PIX;
  localparam int AW   = $clog2(NPIX);

  typedef enum logic [1:0] {IDLE, CLEAR, SWAP} state_t;

  state_t          r_state, w_state_nxt;
  logic            r_front_sel;
  logic            r_swap_pend, w_pend_nxt;
  logic            w_toggle;
  logic [AW-1:0]   r_cnt, w_cnt_nxt;

  logic [PW-1:0]   r_bank0 [NPIX];
  logic [PW-1:0]   r_bank1 [NPIX];

  logic            w_wr_inrange, w_rd_inrange;
  logic [AW-1:0]   w_wr_addr, w_rd_addr;
  logic            w_we;
  logic [AW-1:0]   w_waddr;
  logic [PW-1:0]   w_wdata;
  logic [PW-1:0]   w_rd_word;

  assign w_wr_inrange = (32'(wr_x) < 32'(H_PIX)) && (32'(wr_y) < 32'(V_PIX));
  assign w_rd_inrange = (32'(rd_x) < 32'(H_PIX)) && (32'(rd_y) < 32'(V_PIX));
  assign w_wr_addr    = AW'(32'(wr_y) * 32'(H_PIX) + 32'(wr_x));
  assign w_rd_addr    = AW'(32'(rd_y) * 32'(H_PIX) + 32'(rd_x));

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_pend_nxt  = r_swap_pend;
    w_toggle    = 1'b0;
    wr_ready    = 1'b1;
    busy        = 1'b0;
    w_we        = 1'b0;
    w_waddr     = w_wr_addr;
    w_wdata     = wr_rgb;
    unique case (r_state)
      IDLE: begin
        w_we = wr_en && w_wr_inrange;
        if (clear_req) begin
          w_state_nxt = CLEAR;
          w_cnt_nxt   = '0;
          w_pend_nxt  = swap_req;
        end else if (swap_req) begin
          w_toggle = 1'b1;
        end
      end
      CLEAR: begin
        wr_ready  = 1'b0;
        busy      = 1'b1;
        w_we      = 1'b1;
        w_waddr   = r_cnt;
        w_wdata   = CLEAR_RGB;
        w_cnt_nxt = r_cnt + AW'(1);
        if (swap_req) w_pend_nxt = 1'b1;
        if (r_cnt == AW'(NPIX - 1)) begin
          // a swap_req arriving on the final word still counts as pending
          w_state_nxt = (r_swap_pend || swap_req) ? SWAP : IDLE;
          w_pend_nxt  = 1'b0;
          w_cnt_nxt   = '0;
        end
      end
      SWAP: begin
        busy        = 1'b1;
        w_we        = wr_en && w_wr_inrange;
        w_toggle    = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
    if (rst) w_we = 1'b0;
  end

  assign w_rd_word = r_front_sel ? r_bank1[w_rd_addr] : r_bank0[w_rd_addr];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_front_sel <= 1'b0;
      r_cnt       <= '0;
      r_swap_pend <= 1'b0;
      swap_done   <= 1'b0;
      rd_valid    <= 1'b0;
      rd_rgb      <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_front_sel <= r_front_sel ^ w_toggle;
      r_cnt       <= w_cnt_nxt;
      r_swap_pend <= w_pend_nxt;
      swap_done   <= w_toggle;
      rd_valid    <= rd_en;
      if (rd_en) rd_rgb <= w_rd_inrange ? w_rd_word : '0;
    end
  end

  // back bank is always the one not selected for reads
  always_ff @(posedge clk) begin
    if (w_we) begin
      if (r_front_sel) r_bank0[w_waddr] <= w_wdata;
      else             r_bank1[w_waddr] <= w_wdata;
    end
  end

endmodule

// File: tb/tb_frame_buffer_dbl.sv
// Bench for frame_buffer_dbl: directed vector table, randomized traffic against a
// transaction-level bank model, and hand-written clear/swap/reset sequences.
module tb_frame_buffer_dbl;
  localparam int H = 160;
  localparam int V = 120;
  localparam int N = H * V;
  localparam logic [11:0] CLR = 12'h123;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic [7:0]  wr_x = '0;
  logic [6:0]  wr_y = '0;
  logic [11:0] wr_rgb = '0;
  logic        wr_ready;
  logic        rd_en = 1'b0;
  logic [7:0]  rd_x = '0;
  logic [6:0]  rd_y = '0;
  logic [11:0] rd_rgb;
  logic        rd_valid;
  logic        swap_req = 1'b0;
  logic        swap_done;
  logic        clear_req = 1'b0;
  logic        busy;

  frame_buffer_dbl #(.H_PIX(H), .V_PIX(V), .BPC(4), .CLEAR_RGB(CLR)) dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y), .wr_rgb(wr_rgb), .wr_ready(wr_ready),
    .rd_en(rd_en), .rd_x(rd_x), .rd_y(rd_y), .rd_rgb(rd_rgb), .rd_valid(rd_valid),
    .swap_req(swap_req), .swap_done(swap_done), .clear_req(clear_req), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model: two pixel arrays plus request bookkeeping
  logic [11:0] m_mem   [2][N];
  bit          m_known [2][N];
  int          m_front = 0;
  int          m_clear_left = 0;
  int          m_clear_idx = 0;
  bit          m_pend = 0;
  bit          m_swap_due = 0;
  bit          e_valid = 0;
  logic [11:0] e_rgb = '0;
  bit          e_known = 1;
  bit          e_sd = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    wr_en = 1'b0; rd_en = 1'b0; swap_req = 1'b0; clear_req = 1'b0; rst = 1'b0;
  endtask

  // advance the model by one clock using the inputs now on the pins, then compare
  task automatic cyc();
    int wa, ra, bk;
    bit win, rin;
    win = (int'(wr_x) < H) && (int'(wr_y) < V);
    rin = (int'(rd_x) < H) && (int'(rd_y) < V);
    wa  = int'(wr_y) * H + int'(wr_x);
    ra  = int'(rd_y) * H + int'(rd_x);
    if (rst) begin
      m_front = 0; m_clear_left = 0; m_pend = 0; m_swap_due = 0;
      e_valid = 0; e_rgb = '0; e_known = 1; e_sd = 0;
    end else begin
      bk = 1 - m_front;
      if (rd_en) begin
        e_valid = 1;
        if (rin) begin e_rgb = m_mem[m_front][ra]; e_known = m_known[m_front][ra]; end
        else     begin e_rgb = '0; e_known = 1; end
      end else begin
        e_valid = 0;
      end
      if (wr_en && m_clear_left == 0 && win) begin
        m_mem[bk][wa] = wr_rgb; m_known[bk][wa] = 1;
      end
      e_sd = 0;
      if (m_swap_due) begin
        m_front = bk; e_sd = 1; m_swap_due = 0;
      end else if (m_clear_left > 0) begin
        m_mem[bk][m_clear_idx] = CLR; m_known[bk][m_clear_idx] = 1;
        m_clear_idx++; m_clear_left--;
        if (swap_req) m_pend = 1;
        if (m_clear_left == 0 && m_pend) begin m_swap_due = 1; m_pend = 0; end
      end else if (clear_req) begin
        m_clear_left = N; m_clear_idx = 0; m_pend = swap_req;
      end else if (swap_req) begin
        m_front = bk; e_sd = 1;
      end
    end
    @(posedge clk);
    #1;
    chk("rd_valid", 32'(rd_valid), 32'(e_valid));
    if (e_known) chk("rd_rgb", 32'(rd_rgb), 32'(e_rgb));
    chk("swap_done", 32'(swap_done), 32'(e_sd));
    chk("wr_ready", 32'(wr_ready), 32'(m_clear_left == 0));
    chk("busy", 32'(busy), 32'(m_clear_left > 0 || m_swap_due));
  endtask

  typedef struct {
    logic rst, wen; logic [7:0] wx; logic [6:0] wy; logic [11:0] wrgb;
    logic ren; logic [7:0] rx; logic [6:0] ry; logic sw;
    logic ev; logic [11:0] ergb; logic esd;
  } vec_t;

  function automatic vec_t mkv(input int r, we, wx, wy, wrgb, re, rx, ry, sw, ev, ergb, esd);
    vec_t v;
    v.rst = 1'(r); v.wen = 1'(we); v.wx = 8'(wx); v.wy = 7'(wy); v.wrgb = 12'(wrgb);
    v.ren = 1'(re); v.rx = 8'(rx); v.ry = 7'(ry); v.sw = 1'(sw);
    v.ev = 1'(ev); v.ergb = 12'(ergb); v.esd = 1'(esd);
    return v;
  endfunction

  vec_t tbl [19];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int low, clr_end, sd_seen, k;
    //              rst we  wx  wy  wrgb    re  rx  ry  sw  ev  ergb    esd
    tbl[0]  = mkv(1, 0,   0,  0, 'h000,  0,   0,  0, 0,  0, 'h000, 0);
    tbl[1]  = mkv(0, 1,   3,  2, 'h0F0,  0,   0,  0, 1,  0, 'h000, 1);
    tbl[2]  = mkv(0, 0,   0,  0, 'h000,  1,   3,  2, 0,  1, 'h0F0, 0);
    tbl[3]  = mkv(0, 0,   0,  0, 'h000,  0,   0,  0, 0,  0, 'h0F0, 0);
    tbl[4]  = mkv(0, 1,   3,  2, 'hF00,  0,   0,  0, 0,  0, 'h0F0, 0);
    tbl[5]  = mkv(0, 0,   0,  0, 'h000,  1,   3,  2, 0,  1, 'h0F0, 0);
    tbl[6]  = mkv(0, 0,   0,  0, 'h000,  0,   0,  0, 1,  0, 'h0F0, 1);
    tbl[7]  = mkv(0, 0,   0,  0, 'h000,  1,   3,  2, 0,  1, 'hF00, 0);
    tbl[8]  = mkv(0, 1,   0,  1, 'h111,  0,   0,  0, 0,  0, 'hF00, 0);
    tbl[9]  = mkv(0, 1, 160,  0, 'hABC,  0,   0,  0, 0,  0, 'hF00, 0);
    tbl[10] = mkv(0, 1, 159,119, 'h5A5,  0,   0,  0, 0,  0, 'hF00, 0);
    tbl[11] = mkv(0, 0,   0,  0, 'h000,  1,   3,  2, 1,  1, 'hF00, 1);
    tbl[12] = mkv(0, 0,   0,  0, 'h000,  1, 160,  0, 0,  1, 'h000, 0);
    tbl[13] = mkv(0, 0,   0,  0, 'h000,  1,   0,  1, 0,  1, 'h111, 0);
    tbl[14] = mkv(0, 0,   0,  0, 'h000,  1, 159,119, 0,  1, 'h5A5, 0);
    tbl[15] = mkv(0, 0,   0,  0, 'h000,  1,   0,120, 0,  1, 'h000, 0);
    tbl[16] = mkv(0, 0,   0,  0, 'h000,  1,   3,  2, 0,  1, 'h0F0, 0);
    tbl[17] = mkv(0, 1,   3,  2, 'h777,  0,   0,  0, 1,  0, 'h0F0, 1);
    tbl[18] = mkv(0, 0,   0,  0, 'h000,  1,   3,  2, 0,  1, 'h777, 0);

    for (int i = 0; i < N; i++) begin m_known[0][i] = 0; m_known[1][i] = 0; end
    rst = 1'b1;
    cyc();

    for (int i = 0; i < 19; i++) begin
      idle_inputs();
      rst = tbl[i].rst; wr_en = tbl[i].wen; wr_x = tbl[i].wx; wr_y = tbl[i].wy;
      wr_rgb = tbl[i].wrgb; rd_en = tbl[i].ren; rd_x = tbl[i].rx; rd_y = tbl[i].ry;
      swap_req = tbl[i].sw;
      cyc();
      chk($sformatf("vec%0d_valid", i), 32'(rd_valid), 32'(tbl[i].ev));
      chk($sformatf("vec%0d_rgb", i), 32'(rd_rgb), 32'(tbl[i].ergb));
      chk($sformatf("vec%0d_swap_done", i), 32'(swap_done), 32'(tbl[i].esd));
    end

    // random traffic concentrated on a small corner plus out-of-range coordinates
    for (int i = 0; i < 1500; i++) begin
      idle_inputs();
      wr_en = 1'($urandom); rd_en = 1'($urandom); swap_req = ($urandom % 8 == 0);
      wr_x = ($urandom % 8 == 0) ? 8'(160 + $urandom % 8) : 8'($urandom % 6);
      wr_y = ($urandom % 8 == 0) ? 7'(120 + $urandom % 8) : 7'($urandom % 4);
      rd_x = ($urandom % 8 == 0) ? 8'(160 + $urandom % 8) : 8'($urandom % 6);
      rd_y = ($urandom % 8 == 0) ? 7'(120 + $urandom % 8) : 7'($urandom % 4);
      wr_rgb = 12'($urandom);
      cyc();
    end

    // clear with a deferred swap, ignored writes, and a duplicate swap request
    idle_inputs(); clear_req = 1'b1; cyc();
    low = (wr_ready === 1'b0) ? 1 : 0; clr_end = -1; sd_seen = -1;
    for (k = 1; k < 25000 && sd_seen < 0; k++) begin
      idle_inputs();
      swap_req = (k == 5 || k == 40);
      clear_req = (k == 60);
      wr_en = (k == 10 || k == 11); wr_x = '0; wr_y = '0; wr_rgb = 12'hFFF;
      rd_en = 1'($urandom); rd_x = 8'($urandom % 6); rd_y = 7'($urandom % 4);
      cyc();
      if (wr_ready === 1'b0) low++;
      else if (clr_end < 0) clr_end = k;
      if (swap_done === 1'b1 && sd_seen < 0) sd_seen = k;
    end
    chk("clear_len", 32'(low), 32'(N));
    chk("clear_end_idx", 32'(clr_end), 32'(N));
    chk("deferred_swap_idx", 32'(sd_seen), 32'(N + 1));
    for (int p = 0; p < N; p += 37) begin
      idle_inputs(); rd_en = 1'b1; rd_x = 8'(p % H); rd_y = 7'(p / H);
      cyc();
      chk("cleared_px", 32'(rd_rgb), 32'(CLR));
    end
    idle_inputs(); rd_en = 1'b1; rd_x = 8'd159; rd_y = 7'd119; cyc();
    chk("cleared_last_px", 32'(rd_rgb), 32'(CLR));
    idle_inputs(); rd_en = 1'b1; rd_x = 8'd0; rd_y = 7'd0; cyc();
    chk("write_during_clear_ignored", 32'(rd_rgb), 32'(CLR));

    // reset in the middle of a clear with a swap pending
    idle_inputs(); clear_req = 1'b1; cyc();
    for (k = 1; k <= 100; k++) begin
      idle_inputs(); swap_req = (k == 3); cyc();
    end
    idle_inputs(); rst = 1'b1; cyc();
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_rd_rgb", 32'(rd_rgb), 32'd0);
    chk("rst_swap_done", 32'(swap_done), 32'd0);
    chk("rst_wr_ready", 32'(wr_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 30; i++) begin
      idle_inputs(); rd_en = 1'b1; rd_x = 8'($urandom % 6); rd_y = 7'($urandom % 4);
      cyc();
      chk("post_rst_no_swap", 32'(swap_done), 32'd0);
    end
    idle_inputs(); clear_req = 1'b1; cyc();
    low = (wr_ready === 1'b0) ? 1 : 0; clr_end = -1;
    for (k = 1; k < 25000 && clr_end < 0; k++) begin
      idle_inputs(); cyc();
      if (wr_ready === 1'b0) low++;
      else clr_end = k;
    end
    chk("clear2_len", 32'(low), 32'(N));
    chk("clear2_busy_falls", 32'(busy), 32'd0);
    idle_inputs(); swap_req = 1'b1; cyc();
    for (int i = 0; i < 20; i++) begin
      idle_inputs(); rd_en = 1'b1; rd_x = 8'($urandom % H); rd_y = 7'($urandom % V);
      cyc();
      chk("clear2_px", 32'(rd_rgb), 32'(CLR));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
